// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock and then
// releases the core, retrying a bounded number of times before giving up.
module pll_reset_seq #(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  localparam int MAX_HW  = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_HW > STABLE_CYCLES) ? MAX_HW : STABLE_CYCLES;
  localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);
  localparam int RW      = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t          st, st_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   retry, retry_n, retry_inc;
  logic [7:0]      relock_n;
  logic            sync1, lk;

  assign state     = st;
  assign retry_inc = retry + 1'b1;

  // Counter only advances below each state's terminal value, so it never wraps.
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    retry_n  = retry;
    relock_n = relock_count;
    if (soft_reset) begin
      st_n    = S_HOLD;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      case (st)
        S_HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            st_n  = S_WAIT;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (lk) begin
            st_n  = S_STABLE;
            cnt_n = '0;
          end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            retry_n = retry_inc;
            cnt_n   = '0;
            st_n    = (retry_inc == RW'(MAX_RETRY)) ? S_FAIL : S_HOLD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lk) begin
            st_n  = S_WAIT;
            cnt_n = '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            st_n    = S_RUN;
            cnt_n   = '0;
            retry_n = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lk) begin
            st_n     = S_HOLD;
            cnt_n    = '0;
            relock_n = (relock_count == 8'hFF) ? relock_count : relock_count + 8'd1;
          end
        end
        S_FAIL: begin
          st_n = S_FAIL;
        end
        default: begin
          st_n  = S_HOLD;
          cnt_n = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      st           <= S_HOLD;
      cnt          <= '0;
      retry        <= '0;
      relock_count <= 8'd0;
      sync1        <= 1'b0;
      lk           <= 1'b0;
      pll_rst      <= 1'b1;
      core_reset   <= 1'b1;
      ready        <= 1'b0;
      fail         <= 1'b0;
    end else begin
      sync1        <= pll_locked;
      lk           <= sync1;
      st           <= st_n;
      cnt          <= cnt_n;
      retry        <= retry_n;
      relock_count <= relock_n;
      pll_rst      <= (st_n == S_HOLD) || (st_n == S_FAIL);
      core_reset   <= (st_n != S_RUN);
      ready        <= (st_n == S_RUN);
      fail         <= (st_n == S_FAIL);
    end
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: refclk cycles pll_rst is held high per attempt.
REQ-002 Parameter LOCK_TIMEOUT, default 500000: refclk cycles allowed for lock per attempt.
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-004 Parameter MAX_RETRY, default 7: failed attempts before entering FAIL.
REQ-005 refclk  in  1  50 MHz free-running reference; sole clock of the block.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pll_locked  in  1  PLL locked flag, asynchronous to refclk.
REQ-008 soft_reset  in  1  one-cycle request for a full resequence.
REQ-009 pll_rst  out  1  reset to PLL, active high.
REQ-010 core_reset  out  1  reset to game core, active high.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fail  out  1  high only in FAIL.
REQ-013 state  out  3  HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.
REQ-014 relock_count  out  8  count of lock losses seen in RUN, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value lk.
REQ-016 All outputs SHALL be registered and decoded from state: pll_rst=1 in HOLD and FAIL; core_reset=0 only in RUN.
REQ-017 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to WAIT with the cycle counter cleared.
REQ-018 WAIT with lk=1 SHALL go to STABLE with the counter cleared.
REQ-019 WAIT with lk=0 for LOCK_TIMEOUT cycles SHALL increment the retry count; next state is FAIL if the new count equals MAX_RETRY, otherwise HOLD.
REQ-020 STABLE with lk=0 SHALL return to WAIT with the counter cleared and no retry increment.
REQ-021 STABLE with lk=1 for STABLE_CYCLES consecutive cycles SHALL go to RUN and clear the retry count.
REQ-022 RUN with lk=0 SHALL go to HOLD on the next edge, so core_reset rises in that same cycle, and relock_count SHALL increment with saturation.
REQ-023 FAIL SHALL be terminal: only rst or soft_reset leaves it.
REQ-024 soft_reset in any state SHALL force HOLD and clear the counter, the retry count and fail; relock_count is preserved.
REQ-025 Priority SHALL be rst > soft_reset > lock and timeout events.
REQ-026 The counter SHALL be wide enough for max(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) and SHALL never wrap.

Reset
REQ-027 rst=1 SHALL produce, on the next edge: state=HOLD, pll_rst=1, core_reset=1, ready=0, fail=0, relock_count=0, counter=0, retry count=0, synchronizer=0.
REQ-028 rst asserted mid-sequence, including in RUN, SHALL override everything within one cycle.

Verification
Bench parameters: HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3.
REQ-029 Nominal: release rst with pll_locked=1 -> pll_rst high for 4 cycles; state WAIT, then STABLE; ready=1 and core_reset=0 exactly 8 cycles after STABLE entry.
REQ-030 Glitch: pll_locked drops for 2 cycles during STABLE -> return to WAIT, then STABLE again; ready is delayed and relock_count stays 0.
REQ-031 Lock loss in RUN: drop pll_locked -> core_reset=1 and state=HOLD 3 cycles after the input falls; relock_count=1; on relock, RUN again.
REQ-032 No lock: pll_locked held 0 -> three 4+20 cycle attempts, then state=FAIL, fail=1, pll_rst=1; a soft_reset pulse -> HOLD with fail=0.
REQ-033 Saturation and priority: force 256 lock losses -> relock_count=255. soft_reset and rst asserted together -> reset values of REQ-027.
